// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared types and sizing helpers for the bit-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the counter can reach WIDTH itself without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl_if
// Purpose  : Start/operand request and result bundle of the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;

    modport master (
        output start, a_in, b_in, cin_in,
        input  busy, done, sum_out, cout_out
    );

    modport slave (
        input  start, a_in, b_in, cin_in,
        output busy, done, sum_out, cout_out
    );
endinterface
`default_nettype wire

// File: rtl/full_add.sv
`default_nettype none
// ============================================================================
// Module   : full_add
// Purpose  : Single-bit full adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial adder sequencer, LSB first through one full_add cell.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);
    localparam int                c_cnt_w    = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_a_sh;
    logic [WIDTH-1:0]     r_b_sh;
    logic [WIDTH-1:0]     r_s_sh;
    logic [WIDTH-1:0]     r_sum_out;
    logic                 r_carry;
    logic                 r_cout_out;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     w_s_nxt;
    logic                 w_bit_sum;
    logic                 w_bit_cout;
    logic                 w_load;
    logic                 w_run;
    logic                 w_last;
    logic                 w_busy;
    logic                 w_done;

    full_add u_full_add (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .sum  (w_bit_sum),
        .cout (w_bit_cout)
    );

    // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
    assign w_s_nxt = (r_s_sh >> 1) | (WIDTH'(w_bit_sum) << (WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_run       = 1'b0;
        w_last      = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                w_run  = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_s_sh     <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum_out  <= '0;
            r_cout_out <= 1'b0;
        end else if (w_load) begin
            r_a_sh  <= bus.a_in;
            r_b_sh  <= bus.b_in;
            r_carry <= bus.cin_in;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_s_sh  <= w_s_nxt;
            r_carry <= w_bit_cout;
            r_cnt   <= r_cnt + c_cnt_w'(1);
            // Result registers take the final bit directly so they are valid in DONE.
            if (w_last) begin
                r_sum_out  <= w_s_nxt;
                r_cout_out <= w_bit_cout;
            end
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.sum_out  = r_sum_out;
    assign bus.cout_out = r_cout_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus  ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Timing model: an accepted start makes the unit busy for WIDTH+1 cycles,
    // the last of which is the done cycle; the result is the plain sum.
    int         m_left  = 0;
    int         m1_left = 0;
    logic [8:0] m_res, m_out;
    logic [1:0] m1_res, m1_out;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0; m_res <= '0; m_out <= '0;
        end else if (m_left == 0) begin
            if (bus.start) begin
                m_left <= 9;
                m_res  <= bus.a_in + bus.b_in + bus.cin_in;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_out <= m_res;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_left <= 0; m1_res <= '0; m1_out <= '0;
        end else if (m1_left == 0) begin
            if (bus1.start) begin
                m1_left <= 2;
                m1_res  <= bus1.a_in + bus1.b_in + bus1.cin_in;
            end
        end else begin
            m1_left <= m1_left - 1;
            if (m1_left == 2) m1_out <= m1_res;
        end
    end

    always @(negedge clk) begin
        chk("busy",      32'(bus.busy),  32'(m_left > 0));
        chk("done",      32'(bus.done),  32'(m_left == 1));
        chk("result",    32'({bus.cout_out, bus.sum_out}), 32'(m_out));
        chk("busy_w1",   32'(bus1.busy), 32'(m1_left > 0));
        chk("done_w1",   32'(bus1.done), 32'(m1_left == 1));
        chk("result_w1", 32'({bus1.cout_out, bus1.sum_out}), 32'(m1_out));
    end

    task automatic pulse_start(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(posedge clk); #1;
        bus.a_in = a; bus.b_in = b; bus.cin_in = c; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input bit scramble, output int cyc, output int nbusy);
        bit seen;
        seen  = 1'b0;
        cyc   = 0;
        nbusy = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) nbusy++;
            if (bus.done) seen = 1'b1;
            else if (scramble) begin
                bus.a_in = 8'($urandom); bus.b_in = 8'($urandom); bus.cin_in = 1'($urandom);
            end
        end
        if (!seen) chk({nm, "_timeout"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int cyc, nb, last, ndone, now;
        bit seen;
        bus.start  = 1'b0; bus.a_in  = '0; bus.b_in  = '0; bus.cin_in  = 1'b0;
        bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.cin_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.sum_out), 32'd0);
        chk("rst_cout", 32'(bus.cout_out), 32'd0);

        // FF + 01: full carry ripple, latency and busy length
        pulse_start(8'hFF, 8'h01, 1'b0);
        wait_done("t1", 1'b0, cyc, nb);
        chk("t1_latency", 32'(cyc), 32'd9);
        chk("t1_busy_cycles", 32'(nb), 32'd9);
        chk("t1_sum", 32'(bus.sum_out), 32'h00);
        chk("t1_cout", 32'(bus.cout_out), 32'd1);
        chk("t1_model", 32'(m_out), 32'h100);
        @(negedge clk);
        chk("t1_busy_after", 32'(bus.busy), 32'd0);

        // 5A + 33 + 1 with operand inputs scrambled while running
        pulse_start(8'h5A, 8'h33, 1'b1);
        wait_done("t2", 1'b1, cyc, nb);
        chk("t2_sum", 32'(bus.sum_out), 32'h8E);
        chk("t2_cout", 32'(bus.cout_out), 32'd0);
        chk("t2_model", 32'(m_out), 32'h08E);

        // start held high: one op every WIDTH+2 cycles
        @(posedge clk); #1;
        bus.a_in = 8'h01; bus.b_in = 8'h01; bus.cin_in = 1'b0; bus.start = 1'b1;
        last = -1; ndone = 0; now = 0;
        for (int k = 0; k < 40 && ndone < 3; k++) begin
            @(negedge clk);
            now++;
            if (bus.done) begin
                chk("t3_sum", 32'(bus.sum_out), 32'h02);
                if (last >= 0) chk("t3_period", 32'(now - last), 32'd10);
                last = now;
                ndone++;
            end
        end
        chk("t3_ops", 32'(ndone), 32'd3);
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (12) @(posedge clk);

        // asynchronous reset in the middle of a run
        pulse_start(8'h80, 8'h80, 1'b0);
        repeat (4) @(negedge clk);
        chk("t4_pre_sum", 32'(bus.sum_out), 32'h02);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_sum", 32'(bus.sum_out), 32'd0);
        chk("t4_rst_cout", 32'(bus.cout_out), 32'd0);
        chk("t4_rst_busy", 32'(bus.busy), 32'd0);
        chk("t4_rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pulse_start(8'h80, 8'h80, 1'b0);
        wait_done("t4", 1'b0, cyc, nb);
        chk("t4_latency", 32'(cyc), 32'd9);
        chk("t4_sum", 32'(bus.sum_out), 32'h00);
        chk("t4_cout", 32'(bus.cout_out), 32'd1);

        // WIDTH=1 instance: 1 + 1 + 1
        @(posedge clk); #1;
        bus1.a_in = 1'b1; bus1.b_in = 1'b1; bus1.cin_in = 1'b1; bus1.start = 1'b1;
        @(posedge clk); #1 bus1.start = 1'b0;
        seen = 1'b0; cyc = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            cyc++;
            if (bus1.done) seen = 1'b1;
        end
        chk("t5_seen", 32'(seen), 32'd1);
        chk("t5_latency", 32'(cyc), 32'd2);
        chk("t5_sum", 32'(bus1.sum_out), 32'd1);
        chk("t5_cout", 32'(bus1.cout_out), 32'd1);

        // 200 random operations back-to-back, operands changing every cycle
        @(posedge clk); #1 bus.start = 1'b1;
        ndone = 0;
        for (int k = 0; k < 2500 && ndone < 200; k++) begin
            @(posedge clk); #1;
            bus.a_in = 8'($urandom); bus.b_in = 8'($urandom); bus.cin_in = 1'($urandom);
            if (bus.done) ndone++;
        end
        chk("t6_ops", 32'(ndone), 32'd200);
        bus.start = 1'b0;
        repeat (15) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
